// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO in front of the serialiser.
// sdout is registered from the FSM state, so it trails the state by one cycle.
module uart_tx #(
  parameter int CLKS_PER_BIT = 220,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 wr_en,
  output logic                 full,
  output logic                 sdout,
  output logic                 busy,
  output logic                 tx_done,
  output logic                 overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic                 empty;
  logic                 push;
  logic                 pop;

  logic [1:0]           state;
  logic [CW-1:0]        bit_cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;

  // A full FIFO rejects writes even when the FSM pops in the same cycle.
  assign push = wr_en && !full;
  assign pop  = (state == IDLE) && !empty;
  assign busy = (state != IDLE) || !empty;

  // FIFO storage, no reset needed on the data array
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data;
    end
  end

  // FIFO pointers and registered full/empty flags
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      overflow <= wr_en && full;
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        empty <= 1'b0;
        full  <= ((wr_ptr + PW'(1)) == rd_ptr);
      end else if (pop && !push) begin
        full  <= 1'b0;
        empty <= ((rd_ptr + PW'(1)) == wr_ptr);
      end
    end
  end

  // Frame sequencer; sdout and tx_done reflect the state of the previous cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      sdout   <= 1'b1;
      tx_done <= 1'b0;
    end else begin
      tx_done <= (state == STOP) && (bit_cnt == CNT_LAST);
      case (state)
        START:   sdout <= 1'b0;
        DATA:    sdout <= shreg[0];
        default: sdout <= 1'b1;
      endcase
      case (state)
        IDLE: begin
          if (!empty) begin
            shreg   <= mem[rd_ptr];
            bit_cnt <= '0;
            state   <= START;
          end
        end
        START: begin
          if (bit_cnt == CNT_LAST) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_cnt == CNT_LAST) begin
            bit_cnt <= '0;
            shreg   <= shreg >> 1;
            if (bit_idx == IDX_LAST) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + IW'(1);
            end
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        STOP: begin
          if (bit_cnt == CNT_LAST) begin
            bit_cnt <= '0;
            state   <= IDLE;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          bit_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a bench-side 8N1 receiver pops expected
// bytes from a scoreboard queue; scenario tasks check timing and flags.
module tb_uart_tx;

  localparam int CPB = 220;
  localparam int DB  = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data = 8'h00;
  logic       wr_en = 1'b0;
  logic       full, sdout, busy, tx_done, overflow;

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .data(data), .wr_en(wr_en), .full(full),
    .sdout(sdout), .busy(busy), .tx_done(tx_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  int starts[$];
  int done_cnt = 0;
  bit rx_clear = 1'b0;
  int rx_state = 0;
  int rx_cnt = 0;
  int rx_j = 0;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] exp_b;

  always @(posedge clk) cyc++;

  // Reference receiver: samples mid-bit, scores each completed frame
  always @(negedge clk) begin
    #1;
    if (tx_done === 1'b1) done_cnt++;
    if (rx_clear) begin
      rx_state = 0;
    end else if (rx_state == 0) begin
      if (sdout === 1'b0) begin
        rx_state = 1;
        rx_cnt = 0;
        starts.push_back(cyc);
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % CPB == CPB / 2) begin
        rx_j = rx_cnt / CPB;
        if (rx_j >= 1 && rx_j <= DB) begin
          rx_byte[rx_j-1] = sdout;
        end else if (rx_j > DB) begin
          tests++;
          if (sdout !== 1'b1) begin
            fails++;
            $display("FAIL rx_stop: stop bit=%b required 1", sdout);
          end
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL rx_unexpected: got frame 0x%02h, none expected", rx_byte);
          end else begin
            exp_b = exp_q.pop_front();
            if (rx_byte !== exp_b) begin
              fails++;
              $display("FAIL rx_byte: got 0x%02h required 0x%02h", rx_byte, exp_b);
            end
          end
          rx_state = 0;
        end
      end
    end
  end

  // Called at a negedge; the write is sampled on the next rising edge.
  task automatic write_byte(input logic [7:0] b, input bit exp_full);
    tests++;
    if (full !== exp_full) begin
      fails++;
      $display("FAIL wr_full: full=%b required %b", full, exp_full);
    end
    data = b;
    wr_en = 1'b1;
    if (!exp_full) exp_q.push_back(b);
    @(negedge clk);
    tests++;
    if (overflow !== exp_full) begin
      fails++;
      $display("FAIL wr_overflow: overflow=%b required %b", overflow, exp_full);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (busy !== 1'b0 && n < 30000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL drain_timeout: busy=%b after %0d cycles, required 0", busy, n);
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic check_frames(input string name, input int n_frames);
    tests++;
    if (done_cnt != n_frames) begin
      fails++;
      $display("FAIL %s_tx_done: %0d pulses, required %0d", name, done_cnt, n_frames);
    end
    tests++;
    if (starts.size() != n_frames) begin
      fails++;
      $display("FAIL %s_frames: %0d frames, required %0d", name, starts.size(), n_frames);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_pending: %0d bytes never sent, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (sdout !== 1'b1 || full !== 1'b0 || busy !== 1'b0 || tx_done !== 1'b0 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL reset_vals: sdout=%b full=%b busy=%b tx_done=%b overflow=%b required 1,0,0,0,0",
               sdout, full, busy, tx_done, overflow);
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    tests++;
    if (sdout !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: sdout=%b busy=%b required 1,0", sdout, busy);
    end
  endtask

  task automatic test_single();
    logic [7:0] pat = 8'hA5;
    logic e;
    int b;
    int werr = 0, derr = 0, berr = 0, first = -1;
    done_cnt = 0;
    starts.delete();
    write_byte(pat, 1'b0);
    wr_en = 1'b0;
    for (int k = 0; k < 2210; k++) begin
      if (k < 2 || k >= 2 + 10 * CPB) begin
        e = 1'b1;
      end else begin
        b = (k - 2) / CPB;
        if (b == 0) e = 1'b0;
        else if (b <= DB) e = pat[b-1];
        else e = 1'b1;
      end
      if (sdout !== e) begin
        werr++;
        if (first < 0) first = k;
      end
      if (tx_done !== (k == 2201)) derr++;
      if (busy !== (k < 2201)) berr++;
      @(negedge clk);
    end
    tests++;
    if (werr != 0) begin
      fails++;
      $display("FAIL single_wave: %0d wrong sdout cycles (first at %0d), required 0", werr, first);
    end
    tests++;
    if (derr != 0) begin
      fails++;
      $display("FAIL single_tx_done: %0d wrong tx_done cycles, required 0", derr);
    end
    tests++;
    if (berr != 0) begin
      fails++;
      $display("FAIL single_busy: %0d wrong busy cycles, required 0", berr);
    end
    repeat (10) @(negedge clk);
    check_frames("single", 1);
  endtask

  task automatic test_back_to_back();
    done_cnt = 0;
    starts.delete();
    for (int i = 1; i <= 4; i++) write_byte(8'(i), 1'b0);
    wr_en = 1'b0;
    tests++;
    if (full !== 1'b0) begin
      fails++;
      $display("FAIL b2b_full: full=%b required 0 (one byte already popped)", full);
    end
    wait_drain();
    check_frames("b2b", 4);
    for (int i = 1; i < starts.size(); i++) begin
      tests++;
      if (starts[i] - starts[i-1] != 10 * CPB + 1) begin
        fails++;
        $display("FAIL b2b_period: frame %0d period %0d cycles, required %0d",
                 i, starts[i] - starts[i-1], 10 * CPB + 1);
      end
    end
  endtask

  task automatic test_overflow();
    done_cnt = 0;
    starts.delete();
    for (int i = 0; i < 6; i++) write_byte(8'h10 + 8'(i), (i == 5));
    wr_en = 1'b0;
    @(negedge clk);
    tests++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL ovf_pulse: overflow=%b one cycle later, required 0", overflow);
    end
  endtask

  // Continues from test_overflow: the FSM pops at the 2202nd edge after the first write.
  task automatic test_full_pop();
    repeat (2195) @(negedge clk);
    write_byte(8'h66, 1'b1);
    write_byte(8'h77, 1'b0);
    wr_en = 1'b0;
    tests++;
    if (full !== 1'b1) begin
      fails++;
      $display("FAIL fullpop_count: full=%b after one refill, required 1 (3 entries left)", full);
    end
    wait_drain();
    check_frames("ovf", 6);
  endtask

  task automatic test_reset_midframe();
    int lows = 0, busies = 0;
    write_byte(8'h3C, 1'b0);
    write_byte(8'h11, 1'b0);
    write_byte(8'h22, 1'b0);
    wr_en = 1'b0;
    repeat (697) @(negedge clk);
    reset = 1'b1;
    rx_clear = 1'b1;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    tests++;
    if (sdout !== 1'b1 || busy !== 1'b0 || full !== 1'b0 || tx_done !== 1'b0) begin
      fails++;
      $display("FAIL midrst_vals: sdout=%b busy=%b full=%b tx_done=%b required 1,0,0,0",
               sdout, busy, full, tx_done);
    end
    rx_clear = 1'b0;
    done_cnt = 0;
    starts.delete();
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (sdout !== 1'b1) lows++;
      if (busy !== 1'b0) busies++;
    end
    tests++;
    if (lows != 0 || busies != 0) begin
      fails++;
      $display("FAIL midrst_quiet: %0d low cycles, %0d busy cycles, required 0,0", lows, busies);
    end
    check_frames("midrst", 0);
  endtask

  task automatic test_loopback();
    logic [7:0] pats [4];
    pats = '{8'h00, 8'hFF, 8'h55, 8'h80};
    done_cnt = 0;
    starts.delete();
    for (int i = 0; i < 4; i++) write_byte(pats[i], 1'b0);
    wr_en = 1'b0;
    wait_drain();
    check_frames("loop", 4);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_reset_midframe();
    test_loopback();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
